// File: rtl/ft601_bus_responder.sv
// Device-side stand-in for the FT601 245-synchronous FIFO bus. Words pushed by the
// host side are offered to the bus master, and words the master writes are captured for the host.
module ft601_bus_responder #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int CNT_W    = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             FTDI_nOE,
    input  logic             FTDI_nRD,
    input  logic             FTDI_nWR,
    output logic             FTDI_nRXF,
    output logic             FTDI_nTXE,
    input  logic [31:0]      Bus_Data_In,
    input  logic [3:0]       Bus_BE_In,
    output logic [31:0]      Bus_Data_Out,
    output logic [3:0]       Bus_BE_Out,
    output logic             Bus_OE,
    input  logic [35:0]      Host_TX_Data,
    input  logic             Host_TX_WE,
    output logic             Host_TX_Full,
    output logic [35:0]      Host_RX_Data,
    input  logic             Host_RX_RE,
    output logic             Host_RX_Empty,
    output logic [CNT_W-1:0] Underrun_Cnt,
    output logic [CNT_W-1:0] Overrun_Cnt,
    output logic             Protocol_Err,
    output logic [1:0]       dbg_state
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_CAP = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_CAP = (RAW+1)'(RX_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OE_ARM = 2'd1,
        ST_READ   = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [35:0]  tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TAW:0] tx_count, tx_count_next;
    logic [35:0]  rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RAW:0] rx_count, rx_count_next;

    logic tx_empty, rx_empty;
    logic illegal, rd_ok, wr_ok;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic underrun, overrun;

    // Handshakes: a bus word moves on a rising edge where the strobe is low and the
    // matching registered flag (nRXF for reads, nTXE for writes) is low; a host word
    // moves on an edge where WE/RE is high and the buffer is not full/empty.
    assign tx_empty      = (tx_count == '0);
    assign rx_empty      = (rx_count == '0);
    assign Host_TX_Full  = (tx_count == TX_CAP);
    assign Host_RX_Empty = rx_empty;
    assign dbg_state     = state_q;

    // Any illegal strobe combination blocks both directions for that edge.
    assign illegal = (~FTDI_nRD & FTDI_nOE) | (~FTDI_nWR & ~FTDI_nOE) |
                     (~FTDI_nRD & (state_q == ST_IDLE));
    assign rd_ok   = ~FTDI_nOE & ~FTDI_nRD & ~illegal;
    assign wr_ok   = ~FTDI_nWR & ~illegal;

    assign tx_pop   = rd_ok & ~tx_empty;
    assign underrun = rd_ok & tx_empty;
    assign tx_push  = Host_TX_WE & ~Host_TX_Full;
    assign rx_push  = wr_ok & ~FTDI_nTXE;
    assign overrun  = wr_ok & FTDI_nTXE;
    assign rx_pop   = Host_RX_RE & ~rx_empty;

    always_comb begin
        tx_count_next = tx_count;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count + (TAW+1)'(1);
            2'b01:   tx_count_next = tx_count - (TAW+1)'(1);
            default: tx_count_next = tx_count;
        endcase
        rx_count_next = rx_count;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_next = rx_count + (RAW+1)'(1);
            2'b01:   rx_count_next = rx_count - (RAW+1)'(1);
            default: rx_count_next = rx_count;
        endcase
    end

    always_comb begin
        Bus_OE       = ~FTDI_nOE & ~Reset;
        Bus_Data_Out = '0;
        Bus_BE_Out   = '0;
        Host_RX_Data = '0;
        if (!tx_empty) begin
            Bus_Data_Out = tx_mem[tx_rd_ptr][31:0];
            Bus_BE_Out   = tx_mem[tx_rd_ptr][35:32];
        end
        if (!rx_empty) begin
            Host_RX_Data = rx_mem[rx_rd_ptr];
        end
    end

    always_comb begin
        state_d = state_q;
        if (FTDI_nOE && FTDI_nRD && FTDI_nWR) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!FTDI_nOE && FTDI_nRD)      state_d = ST_OE_ARM;
                    else if (!FTDI_nWR && FTDI_nOE) state_d = ST_WRITE;
                end
                ST_OE_ARM: begin
                    if (FTDI_nOE)       state_d = ST_IDLE;
                    else if (!FTDI_nRD) state_d = ST_READ;
                end
                ST_READ: begin
                    if (FTDI_nOE) state_d = ST_IDLE;
                end
                ST_WRITE: state_d = ST_WRITE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge Clock) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= Host_TX_Data;
        if (rx_push) rx_mem[rx_wr_ptr] <= {Bus_BE_In, Bus_Data_In};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            tx_count     <= '0;
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            rx_count     <= '0;
            FTDI_nRXF    <= 1'b1;
            FTDI_nTXE    <= 1'b1;
            Underrun_Cnt <= '0;
            Overrun_Cnt  <= '0;
            Protocol_Err <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_count  <= tx_count_next;
            rx_count  <= rx_count_next;
            FTDI_nRXF <= (tx_count_next == '0);
            FTDI_nTXE <= (rx_count_next == RX_CAP);
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TAW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TAW'(1);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RAW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RAW'(1);
            if (underrun && (Underrun_Cnt != '1)) Underrun_Cnt <= Underrun_Cnt + CNT_W'(1);
            if (overrun && (Overrun_Cnt != '1))   Overrun_Cnt  <= Overrun_Cnt + CNT_W'(1);
            if (illegal) Protocol_Err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ft601_bus_responder.sv
// Bench for ft601_bus_responder: directed bus/host sequences, with queue-based
// scoreboards for the master-read stream and the host-capture stream.
module tb_ft601_bus_responder;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        FTDI_nOE, FTDI_nRD, FTDI_nWR;
    logic        FTDI_nRXF, FTDI_nTXE;
    logic [31:0] Bus_Data_In;
    logic [3:0]  Bus_BE_In;
    logic [31:0] Bus_Data_Out;
    logic [3:0]  Bus_BE_Out;
    logic        Bus_OE;
    logic [35:0] Host_TX_Data;
    logic        Host_TX_WE;
    logic        Host_TX_Full;
    logic [35:0] Host_RX_Data;
    logic        Host_RX_RE;
    logic        Host_RX_Empty;
    logic [15:0] Underrun_Cnt, Overrun_Cnt;
    logic        Protocol_Err;
    logic [1:0]  dbg_state;

    logic [35:0] rd_exp_q[$];
    logic [35:0] rx_exp_q[$];
    int checks   = 0;
    int failures = 0;

    ft601_bus_responder #(.TX_DEPTH(16), .RX_DEPTH(16), .CNT_W(16)) dut (
        .Clock(Clock), .Reset(Reset),
        .FTDI_nOE(FTDI_nOE), .FTDI_nRD(FTDI_nRD), .FTDI_nWR(FTDI_nWR),
        .FTDI_nRXF(FTDI_nRXF), .FTDI_nTXE(FTDI_nTXE),
        .Bus_Data_In(Bus_Data_In), .Bus_BE_In(Bus_BE_In),
        .Bus_Data_Out(Bus_Data_Out), .Bus_BE_Out(Bus_BE_Out), .Bus_OE(Bus_OE),
        .Host_TX_Data(Host_TX_Data), .Host_TX_WE(Host_TX_WE), .Host_TX_Full(Host_TX_Full),
        .Host_RX_Data(Host_RX_Data), .Host_RX_RE(Host_RX_RE), .Host_RX_Empty(Host_RX_Empty),
        .Underrun_Cnt(Underrun_Cnt), .Overrun_Cnt(Overrun_Cnt),
        .Protocol_Err(Protocol_Err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic push_tx(input logic [35:0] w, input bit expect_out);
        Host_TX_Data = w;
        Host_TX_WE   = 1'b1;
        if (expect_out) rd_exp_q.push_back(w);
        tick();
        Host_TX_WE = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_nrxf"},     64'(FTDI_nRXF), 64'd1);
        check({tag, "_txfull"},   64'(Host_TX_Full), 64'd0);
        check({tag, "_rxempty"},  64'(Host_RX_Empty), 64'd1);
        check({tag, "_underrun"}, 64'(Underrun_Cnt), 64'd0);
        check({tag, "_overrun"},  64'(Overrun_Cnt), 64'd0);
        check({tag, "_perr"},     64'(Protocol_Err), 64'd0);
        check({tag, "_busoe"},    64'(Bus_OE), 64'd0);
        check({tag, "_busdata"},  64'(Bus_Data_Out), 64'd0);
    endtask

    // scoreboard monitor: compares each word on the edge that transfers it
    logic [35:0] exp_w;
    always @(negedge Clock) begin
        if (!Reset && !FTDI_nOE && !FTDI_nRD && !FTDI_nRXF) begin
            if (rd_exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_unexpected actual=%0h required=none", {Bus_BE_Out, Bus_Data_Out});
            end else begin
                exp_w = rd_exp_q.pop_front();
                check("rd_word", 64'({Bus_BE_Out, Bus_Data_Out}), 64'(exp_w));
            end
        end
        if (!Reset && Host_RX_RE && !Host_RX_Empty) begin
            if (rx_exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx_unexpected actual=%0h required=none", Host_RX_Data);
            end else begin
                exp_w = rx_exp_q.pop_front();
                check("rx_word", 64'(Host_RX_Data), 64'(exp_w));
            end
        end
    end

    initial begin
        Reset = 1'b1;
        FTDI_nOE = 1'b1; FTDI_nRD = 1'b1; FTDI_nWR = 1'b1;
        Bus_Data_In = '0; Bus_BE_In = '0;
        Host_TX_Data = '0; Host_TX_WE = 1'b0; Host_RX_RE = 1'b0;

        // T1 reset
        tick();
        check_reset_values("t1");
        check("t1_ntxe_in_reset", 64'(FTDI_nTXE), 64'd1);
        tick();
        check("t1_ntxe_in_reset2", 64'(FTDI_nTXE), 64'd1);
        Reset = 1'b0;
        tick();
        check("t1_ntxe_after", 64'(FTDI_nTXE), 64'd0);
        check("t1_nrxf_after", 64'(FTDI_nRXF), 64'd1);
        check("t1_state", 64'(dbg_state), 64'd0);

        // T2 read burst
        push_tx(36'h1_00000001, 1'b1);
        check("t2_nrxf_fall", 64'(FTDI_nRXF), 64'd0);
        push_tx(36'hF_00000002, 1'b1);
        push_tx(36'hF_00000003, 1'b1);
        FTDI_nOE = 1'b0;
        tick();
        check("t2_bus_oe", 64'(Bus_OE), 64'd1);
        check("t2_head", 64'({Bus_BE_Out, Bus_Data_Out}), 64'h1_00000001);
        FTDI_nRD = 1'b0;
        tick();
        tick();
        check("t2_nrxf_w2", 64'(FTDI_nRXF), 64'd0);
        tick();
        check("t2_nrxf_rise", 64'(FTDI_nRXF), 64'd1);
        FTDI_nRD = 1'b1; FTDI_nOE = 1'b1;
        tick();
        check("t2_underrun", 64'(Underrun_Cnt), 64'd0);
        check("t2_perr", 64'(Protocol_Err), 64'd0);

        // T3 write fill
        for (int i = 1; i <= 18; i++) begin
            Bus_Data_In = 32'hA500_0000 | 32'(i);
            Bus_BE_In   = 4'(i);
            FTDI_nWR    = 1'b0;
            if (i <= 16) rx_exp_q.push_back({4'(i), 32'hA500_0000 | 32'(i)});
            tick();
            if (i == 1) begin
                check("t3_first_visible", 64'(Host_RX_Data), 64'h1_A5000001);
                check("t3_rx_nonempty", 64'(Host_RX_Empty), 64'd0);
            end
            if (i == 15) check("t3_ntxe_15", 64'(FTDI_nTXE), 64'd0);
            if (i == 16) check("t3_ntxe_16", 64'(FTDI_nTXE), 64'd1);
        end
        FTDI_nWR = 1'b1;
        tick();
        check("t3_overrun", 64'(Overrun_Cnt), 64'd2);
        Host_RX_RE = 1'b1;
        repeat (16) tick();
        Host_RX_RE = 1'b0;
        check("t3_rx_drained", 64'(Host_RX_Empty), 64'd1);
        check("t3_ntxe_free", 64'(FTDI_nTXE), 64'd0);
        check("t3_rx_q", 64'(rx_exp_q.size()), 64'd0);

        // T4 underrun
        push_tx(36'h5_ABCD0004, 1'b1);
        FTDI_nOE = 1'b0;
        tick();
        FTDI_nRD = 1'b0;
        repeat (4) tick();
        check("t4_underrun", 64'(Underrun_Cnt), 64'd3);
        check("t4_bus_zero", 64'({Bus_BE_Out, Bus_Data_Out}), 64'd0);
        FTDI_nRD = 1'b1; FTDI_nOE = 1'b1;
        tick();

        // T5 concurrency: TX held at 15 while pushing and popping on the same edge
        for (int k = 0; k < 15; k++) push_tx({4'(k), 32'hC0DE_0000 + 32'(k)}, 1'b1);
        check("t5_not_full_15", 64'(Host_TX_Full), 64'd0);
        FTDI_nOE = 1'b0;
        tick();
        for (int k = 15; k < 100; k++) begin
            Host_TX_Data = {4'(k), 32'hC0DE_0000 + 32'(k)};
            Host_TX_WE   = 1'b1;
            FTDI_nRD     = 1'b0;
            rd_exp_q.push_back({4'(k), 32'hC0DE_0000 + 32'(k)});
            tick();
            check("t5_full_stream", 64'(Host_TX_Full), 64'd0);
        end
        Host_TX_WE = 1'b0; FTDI_nRD = 1'b1;
        tick();
        push_tx(36'h9_C0DE0064, 1'b1);
        check("t5_full_16", 64'(Host_TX_Full), 64'd1);
        push_tx(36'hF_DEADBEEF, 1'b0);
        check("t5_full_ignored", 64'(Host_TX_Full), 64'd1);
        FTDI_nRD = 1'b0;
        repeat (16) tick();
        check("t5_nrxf_drained", 64'(FTDI_nRXF), 64'd1);
        FTDI_nRD = 1'b1; FTDI_nOE = 1'b1;
        tick();
        check("t5_underrun", 64'(Underrun_Cnt), 64'd3);
        check("t5_rd_q", 64'(rd_exp_q.size()), 64'd0);

        // T6 protocol error, then reset mid-burst
        FTDI_nOE = 1'b0; FTDI_nWR = 1'b0;
        Bus_Data_In = 32'h0BAD_0BAD; Bus_BE_In = 4'hF;
        tick();
        check("t6_perr", 64'(Protocol_Err), 64'd1);
        check("t6_no_capture", 64'(Host_RX_Empty), 64'd1);
        check("t6_no_overrun", 64'(Overrun_Cnt), 64'd2);
        FTDI_nOE = 1'b1; FTDI_nWR = 1'b1;
        tick();
        check("t6_perr_sticky", 64'(Protocol_Err), 64'd1);
        push_tx(36'h3_11112222, 1'b0);
        push_tx(36'h3_33334444, 1'b0);
        FTDI_nWR = 1'b0;
        tick();
        tick();
        check("t6_burst_captured", 64'(Host_RX_Empty), 64'd0);
        Reset = 1'b1;
        tick();
        check_reset_values("t6");
        check("t6_ntxe_in_reset", 64'(FTDI_nTXE), 64'd1);
        FTDI_nWR = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        check("t6_ntxe_after", 64'(FTDI_nTXE), 64'd0);
        check_reset_values("t6_post");
        check("t6_state", 64'(dbg_state), 64'd0);

        // final report
        check("end_rd_q", 64'(rd_exp_q.size()), 64'd0);
        check("end_rx_q", 64'(rx_exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
